wb_slv_dec: RTL and testbench

//  Wishbone 1-master-to-4-slave decoder/router; the responder-side counterpart of the
//  4-master grant arbiter. Takes the arbitrated master bus, decodes address to one
//  of 4 slave ports, registers the transaction, and returns a single-cycle ack/err.

---
 rtl/wb_slv_dec_if.sv | 43 ++++
 rtl/wb_slv_dec.sv | 164 ++++++++++++++++
 tb/tb_wb_slv_dec.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_slv_dec_if.sv
// Wishbone 1-master / 4-slave bus bundle for the wb_slv_dec router.
// Signal names are those seen from the router: *_i are router inputs, *_o are router outputs.
interface wb_slv_dec_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // master side
    logic              m_cyc_i;
    logic              m_stb_i;
    logic              m_we_i;
    logic [AW-1:0]     m_adr_i;
    logic [DW/8-1:0]   m_sel_i;
    logic [DW-1:0]     m_dat_i;
    logic [DW-1:0]     m_dat_o;
    logic              m_ack_o;
    logic              m_err_o;
    // slave side
    logic [3:0]        s_cyc_o;
    logic [3:0]        s_stb_o;
    logic              s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW/8-1:0]   s_sel_o;
    logic [DW-1:0]     s_dat_o;
    logic [4*DW-1:0]   s_dat_i;
    logic [3:0]        s_ack_i;
    logic [3:0]        s_err_i;

    // router view
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    // environment view (upstream master plus the four downstream slaves)
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i
    );
endinterface

// File: rtl/wb_slv_dec.sv
// Wishbone 1-master-to-4-slave address decoder/router.
// A request is latched in IDLE, driven to the decoded slave during ACCESS, and
// answered to the master with a single-cycle ack or err in RESP. Unmapped
// addresses, slave errors and hung slaves (timeout) all end in m_err_o.
module wb_slv_dec #(
    parameter int             AW       = 32,
    parameter int             DW       = 32,
    parameter logic [4*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [4*AW-1:0] SLV_MASK = {4{32'hF000_0000}},
    parameter int             TMO_W    = 8,
    parameter int             TMO_CYC  = 255
) (
    input  logic              clk,
    input  logic              rstn,
    wb_slv_dec_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);
    localparam bit               TMO_EN  = (TMO_CYC != 0);

    state_t            r_state;
    state_t            w_nxt;
    logic [TMO_W-1:0]  r_cnt;
    logic [TMO_W-1:0]  w_cnt_inc;
    logic [3:0]        r_ssel;      // one-hot slave of the current transaction, held through RESP
    logic [3:0]        r_scyc;      // live slave cycle/strobe
    logic              r_we;
    logic [AW-1:0]     r_adr;
    logic [DW/8-1:0]   r_bsel;
    logic [DW-1:0]     r_wdat;
    logic [DW-1:0]     r_rdat;
    logic              r_ack;
    logic              r_err;

    logic [3:0]        w_hit;
    logic [3:0]        w_onehot;
    logic              w_sack;
    logic              w_serr;
    logic [DW-1:0]     w_sdat;
    logic              w_acc;
    logic              w_set_ack;
    logic              w_set_err;

    assign w_cnt_inc = r_cnt + TMO_W'(1);
    assign w_sack    = |(bus.s_ack_i & r_ssel);
    assign w_serr    = |(bus.s_err_i & r_ssel);

    // address decode; scanning high to low leaves the lowest hit index selected
    always_comb begin
        w_hit    = '0;
        w_onehot = '0;
        for (int i = 0; i < 4; i++)
            w_hit[i] = (bus.m_adr_i & SLV_MASK[i*AW +: AW]) ==
                       (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]);
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    // read-data mux from the selected slave
    always_comb begin
        w_sdat = '0;
        for (int i = 0; i < 4; i++)
            if (r_ssel[i]) w_sdat = w_sdat | bus.s_dat_i[i*DW +: DW];
    end

    // next state and response decisions; abort beats any slave response,
    // slave err beats ack, and a slave response beats the timeout
    always_comb begin
        w_nxt     = r_state;
        w_acc     = 1'b0;
        w_set_ack = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    w_acc = 1'b1;
                    if (|w_hit) begin
                        w_nxt = ACCESS;
                    end else begin
                        w_nxt     = RESP;
                        w_set_err = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (!bus.m_cyc_i) begin
                    w_nxt = IDLE;
                end else if (w_serr) begin
                    w_nxt     = RESP;
                    w_set_err = 1'b1;
                end else if (w_sack) begin
                    w_nxt     = RESP;
                    w_set_ack = 1'b1;
                end else if (TMO_EN && (w_cnt_inc == TMO_LIM)) begin
                    w_nxt     = RESP;
                    w_set_err = 1'b1;
                end
            end
            RESP:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    // latched request, slave strobes, timeout count and master response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_ssel <= '0;
            r_scyc <= '0;
            r_we   <= 1'b0;
            r_adr  <= '0;
            r_bsel <= '0;
            r_wdat <= '0;
            r_rdat <= '0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ack <= w_set_ack;
            r_err <= w_set_err;
            if (w_acc) begin
                r_we   <= bus.m_we_i;
                r_adr  <= bus.m_adr_i;
                r_bsel <= bus.m_sel_i;
                r_wdat <= bus.m_dat_i;
                r_ssel <= w_onehot;
                r_scyc <= w_onehot;
                r_cnt  <= '0;
            end else begin
                if (w_nxt != ACCESS) r_scyc <= '0;
                // saturate so a disabled timeout can never wrap
                if (r_state == ACCESS && r_cnt != '1) r_cnt <= w_cnt_inc;
            end
            // only read acks refresh the returned data
            if (w_set_ack && !r_we) r_rdat <= w_sdat;
        end
    end

    assign bus.m_dat_o = r_rdat;
    assign bus.m_ack_o = r_ack;
    assign bus.m_err_o = r_err;
    assign bus.s_cyc_o = r_scyc;
    assign bus.s_stb_o = r_scyc;
    assign bus.s_we_o  = r_we;
    assign bus.s_adr_o = r_adr;
    assign bus.s_sel_o = r_bsel;
    assign bus.s_dat_o = r_wdat;

endmodule

// File: tb/tb_wb_slv_dec.sv
// Directed bench for wb_slv_dec: read, waited write, unmapped, timeout,
// err/ack collision with a spurious ack, abort, async reset and back-to-back.
module tb_wb_slv_dec;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_err;

    wb_slv_dec_if #(.AW(32), .DW(32)) bus ();

    wb_slv_dec #(.AW(32), .DW(32), .TMO_W(8), .TMO_CYC(255)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs set and outputs read 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        bus.m_we_i  = we;
        bus.m_adr_i = adr;
        bus.m_sel_i = 4'hF;
        bus.m_dat_i = dat;
    endtask

    task automatic idle_bus();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.s_ack_i = 4'b0;
        bus.s_err_i = 4'b0;
    endtask

    initial begin
        int n;
        n_chk = 0;
        n_err = 0;
        rstn  = 1'b0;
        idle_bus();
        bus.m_we_i  = 1'b0;
        bus.m_adr_i = '0;
        bus.m_sel_i = '0;
        bus.m_dat_i = '0;
        bus.s_dat_i = '0;
        tick();
        tick();
        chk("rst_cyc", 64'(bus.s_cyc_o), 64'h0);
        chk("rst_stb", 64'(bus.s_stb_o), 64'h0);
        chk("rst_ack", 64'(bus.m_ack_o), 64'h0);
        chk("rst_err", 64'(bus.m_err_o), 64'h0);
        chk("rst_mdat", 64'(bus.m_dat_o), 64'h0);
        chk("rst_sadr", 64'(bus.s_adr_o), 64'h0);
        rstn = 1'b1;
        tick();

        // 1: zero-wait read from slave1
        req(1'b0, 32'h1000_0010, 32'h0);
        tick();
        chk("t1_stb", 64'(bus.s_stb_o), 64'h2);
        chk("t1_cyc", 64'(bus.s_cyc_o), 64'h2);
        chk("t1_adr", 64'(bus.s_adr_o), 64'h1000_0010);
        chk("t1_noack", 64'(bus.m_ack_o), 64'h0);
        bus.s_ack_i         = 4'b0010;
        bus.s_dat_i[32+:32] = 32'hDEAD_BEEF;
        tick();
        chk("t1_ack", 64'(bus.m_ack_o), 64'h1);
        chk("t1_err", 64'(bus.m_err_o), 64'h0);
        chk("t1_stbdrop", 64'(bus.s_stb_o), 64'h0);
        chk("t1_mdat", 64'(bus.m_dat_o), 64'hDEAD_BEEF);
        idle_bus();
        tick();
        chk("t1_ack1", 64'(bus.m_ack_o), 64'h0);

        // 2: write to slave3 with 5 wait states
        req(1'b1, 32'h3000_0004, 32'h1234_5678);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t2_stb", 64'(bus.s_stb_o), 64'h8);
            chk("t2_sdat", 64'(bus.s_dat_o), 64'h1234_5678);
            chk("t2_sadr", 64'(bus.s_adr_o), 64'h3000_0004);
            chk("t2_we", 64'(bus.s_we_o), 64'h1);
            chk("t2_noack", 64'(bus.m_ack_o), 64'h0);
            if (i == 5) begin
                bus.s_ack_i          = 4'b1000;
                bus.s_dat_i[96+:32]  = 32'hAAAA_5555;
            end
            tick();
        end
        chk("t2_ack", 64'(bus.m_ack_o), 64'h1);
        chk("t2_mdat", 64'(bus.m_dat_o), 64'hDEAD_BEEF);
        chk("t2_stbdrop", 64'(bus.s_stb_o), 64'h0);
        idle_bus();
        tick();
        chk("t2_ack1", 64'(bus.m_ack_o), 64'h0);

        // 3: unmapped address
        req(1'b0, 32'h5000_0000, 32'h0);
        tick();
        chk("t3_stb", 64'(bus.s_stb_o), 64'h0);
        chk("t3_err", 64'(bus.m_err_o), 64'h1);
        chk("t3_ack", 64'(bus.m_ack_o), 64'h0);
        idle_bus();
        tick();
        chk("t3_err1", 64'(bus.m_err_o), 64'h0);

        // 4: slave2 never answers
        req(1'b0, 32'h2000_0000, 32'h0);
        tick();
        n = 0;
        while (bus.s_stb_o == 4'b0100 && bus.m_err_o == 1'b0 && n < 300) begin
            n++;
            tick();
        end
        chk("t4_cycles", 64'(n), 64'd255);
        chk("t4_err", 64'(bus.m_err_o), 64'h1);
        chk("t4_stbdrop", 64'(bus.s_stb_o), 64'h0);
        chk("t4_mdat", 64'(bus.m_dat_o), 64'hDEAD_BEEF);
        idle_bus();
        tick();
        chk("t4_err1", 64'(bus.m_err_o), 64'h0);

        // 5: spurious slave1 ack, then slave0 ack+err together
        req(1'b0, 32'h0000_0008, 32'h0);
        tick();
        chk("t5_stb", 64'(bus.s_stb_o), 64'h1);
        bus.s_ack_i         = 4'b0010;
        bus.s_dat_i[32+:32] = 32'h0BAD_0BAD;
        tick();
        chk("t5_spur_stb", 64'(bus.s_stb_o), 64'h1);
        chk("t5_spur_ack", 64'(bus.m_ack_o), 64'h0);
        bus.s_ack_i        = 4'b0001;
        bus.s_err_i        = 4'b0001;
        bus.s_dat_i[0+:32] = 32'h1111_2222;
        tick();
        chk("t5_err", 64'(bus.m_err_o), 64'h1);
        chk("t5_ack", 64'(bus.m_ack_o), 64'h0);
        chk("t5_mdat", 64'(bus.m_dat_o), 64'hDEAD_BEEF);
        idle_bus();
        tick();

        // 6a: master drops cycle mid-ACCESS
        req(1'b0, 32'h1000_0000, 32'h0);
        tick();
        chk("t6a_cyc", 64'(bus.s_cyc_o), 64'h2);
        idle_bus();
        tick();
        chk("t6a_drop", 64'(bus.s_cyc_o), 64'h0);
        chk("t6a_ack", 64'(bus.m_ack_o), 64'h0);
        chk("t6a_err", 64'(bus.m_err_o), 64'h0);
        tick();
        chk("t6a_ack1", 64'(bus.m_ack_o), 64'h0);
        chk("t6a_err1", 64'(bus.m_err_o), 64'h0);

        // 6b: async reset mid-ACCESS
        req(1'b0, 32'h3000_0000, 32'h0);
        tick();
        chk("t6b_cyc", 64'(bus.s_cyc_o), 64'h8);
        rstn = 1'b0;
        #1;
        chk("t6b_cyc0", 64'(bus.s_cyc_o), 64'h0);
        chk("t6b_adr0", 64'(bus.s_adr_o), 64'h0);
        chk("t6b_mdat0", 64'(bus.m_dat_o), 64'h0);
        idle_bus();
        tick();
        rstn = 1'b1;
        tick();
        chk("t6b_ack", 64'(bus.m_ack_o), 64'h0);
        chk("t6b_err", 64'(bus.m_err_o), 64'h0);

        // back-to-back: read slave0 then unmapped, second accepted right after RESP
        req(1'b0, 32'h0000_0100, 32'h0);
        tick();
        chk("bb_stb", 64'(bus.s_stb_o), 64'h1);
        bus.s_ack_i        = 4'b0001;
        bus.s_dat_i[0+:32] = 32'hCAFE_F00D;
        tick();
        chk("bb_ack", 64'(bus.m_ack_o), 64'h1);
        chk("bb_mdat", 64'(bus.m_dat_o), 64'hCAFE_F00D);
        bus.s_ack_i = 4'b0;
        req(1'b1, 32'h7000_0000, 32'h0);
        tick();
        chk("bb_idle", 64'(bus.m_ack_o), 64'h0);
        chk("bb_idle_err", 64'(bus.m_err_o), 64'h0);
        tick();
        chk("bb_err", 64'(bus.m_err_o), 64'h1);
        chk("bb_mdat2", 64'(bus.m_dat_o), 64'hCAFE_F00D);
        idle_bus();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
